avr_timer_n: RTL and testbench

- Parametrised timer/counter peripheral for the AVR core, replacing the fixed single-mode timer built into the CPU.
- Sits on the core's I/O register bus and feeds interrupt request lines to the core's interrupt logic.
- Generalised in counter width and compare-channel count; adds CTC and fast-PWM modes, per-channel output pins, and AVR-style atomic 16-bit access.

---
 rtl/avr_timer_n.sv | 171 +++++++++++++++++
 tb/tb_avr_timer_n.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avr_timer_n.sv
// rtl/avr_timer_n.sv - parametrised AVR timer/counter: normal, CTC and fast-PWM modes
// with buffered 16-bit register access and per-channel compare outputs.
module avr_timer_n #(
  parameter int WIDTH = 8,
  parameter int NCMP  = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            locked,
  input  logic [3:0]      io_a,
  input  logic [7:0]      io_din,
  input  logic            io_w,
  input  logic            io_r,
  output logic [7:0]      io_dout,
  output logic [NCMP-1:0] oc,
  output logic            irq_ovf,
  output logic [NCMP-1:0] irq_cmp,
  input  logic            ack_ovf,
  input  logic [NCMP-1:0] ack_cmp
);
  localparam logic [WIDTH-1:0] TOP = '1;
  localparam logic [1:0] MODE_CTC = 2'd1;
  localparam logic [1:0] MODE_PWM = 2'd2;

  logic [WIDTH-1:0]            cnt_q, cnt_d;
  logic [4:0]                  ctrl_q, ctrl_d;
  logic [NCMP:0]               imsk_q, imsk_d, iflg_q, iflg_d;
  logic [NCMP-1:0][WIDTH-1:0]  cmp_sh_q, cmp_sh_d, cmp_act_q, cmp_act_d;
  logic [7:0]                  temp_q, temp_d;
  logic [9:0]                  pre_q, pre_d;
  logic                        skip_q, skip_d;
  logic [NCMP-1:0]             oc_q, oc_d, irq_cmp_q, irq_cmp_d;
  logic                        irq_ovf_q, irq_ovf_d;

  logic                        tick, pwm, cnt_wr, wrap;
  logic [1:0]                  mode;
  logic [15:0]                 wdata16, cnt16, rd_cmp16;
  logic [NCMP:0]               set_f, clr_f;
  logic [NCMP-1:0][WIDTH-1:0]  cmp_eff;

  assign cnt16 = 16'(cnt_q);

  always_comb begin
    mode = ctrl_q[4:3];
    pwm  = (mode == MODE_PWM);
    case (ctrl_q[2:0])
      3'd1:    tick = 1'b1;
      3'd2:    tick = &pre_q[2:0];
      3'd3:    tick = &pre_q[5:0];
      3'd4:    tick = &pre_q[7:0];
      3'd5:    tick = &pre_q;
      default: tick = 1'b0;
    endcase

    pre_d    = pre_q + 10'd1;
    ctrl_d   = ctrl_q;
    imsk_d   = imsk_q;
    temp_d   = temp_q;
    cmp_sh_d = cmp_sh_q;
    cnt_d    = cnt_q;
    skip_d   = skip_q;
    oc_d     = oc_q;
    set_f    = '0;
    clr_f    = {ack_cmp, ack_ovf};
    cnt_wr   = io_w && (io_a == 4'd3);
    // Low-byte writes commit the high byte previously parked in temp.
    wdata16  = (WIDTH == 16) ? {temp_q, io_din} : {8'h00, io_din};

    if (io_r && (io_a == 4'd3) && (WIDTH == 16)) temp_d = cnt16[15:8];
    if (io_w) begin
      case (io_a)
        4'd0:    ctrl_d = io_din[4:0];
        4'd1:    imsk_d = io_din[NCMP:0];
        4'd2:    clr_f  = clr_f | io_din[NCMP:0];
        4'd4:    if (WIDTH == 16) temp_d = io_din;
        default: ;
      endcase
      for (int k = 0; k < NCMP; k++) begin
        if (io_a == 4'(5 + 2 * k)) cmp_sh_d[k] = WIDTH'(wdata16);
        if ((io_a == 4'(6 + 2 * k)) && (WIDTH == 16)) temp_d = io_din;
      end
    end

    cmp_eff = pwm ? cmp_act_q : cmp_sh_q;
    if (cnt_wr) begin
      cnt_d  = WIDTH'(wdata16);
      skip_d = 1'b1;
    end else if (tick) begin
      skip_d = 1'b0;
      if ((mode == MODE_CTC) && (cnt_q == cmp_eff[0])) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
        if (cnt_q == TOP) set_f[0] = 1'b1;
      end
      if (!skip_q) begin
        for (int k = 0; k < NCMP; k++) begin
          if (cnt_q == cmp_eff[k]) begin
            set_f[k+1] = 1'b1;
            if (!pwm) oc_d[k] = ~oc_q[k];
          end
        end
      end
    end
    if (pwm) begin
      for (int k = 0; k < NCMP; k++) oc_d[k] = (cnt_q < cmp_act_q[k]);
    end

    // Outside PWM the active set tracks the written values, so entering PWM starts fresh.
    wrap = tick && !cnt_wr && (cnt_q == TOP);
    if (!pwm)      cmp_act_d = cmp_sh_d;
    else if (wrap) cmp_act_d = cmp_sh_d;
    else           cmp_act_d = cmp_act_q;

    iflg_d    = (iflg_q & ~clr_f) | set_f;
    irq_ovf_d = iflg_q[0] & imsk_q[0];
    irq_cmp_d = iflg_q[NCMP:1] & imsk_q[NCMP:1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      ctrl_q    <= '0;
      imsk_q    <= '0;
      iflg_q    <= '0;
      cmp_sh_q  <= '0;
      cmp_act_q <= '0;
      temp_q    <= '0;
      pre_q     <= '0;
      skip_q    <= 1'b0;
      oc_q      <= '0;
      irq_ovf_q <= 1'b0;
      irq_cmp_q <= '0;
    end else if (locked) begin
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      imsk_q    <= imsk_d;
      iflg_q    <= iflg_d;
      cmp_sh_q  <= cmp_sh_d;
      cmp_act_q <= cmp_act_d;
      temp_q    <= temp_d;
      pre_q     <= pre_d;
      skip_q    <= skip_d;
      oc_q      <= oc_d;
      irq_ovf_q <= irq_ovf_d;
      irq_cmp_q <= irq_cmp_d;
    end
  end

  always_comb begin
    io_dout  = 8'h00;
    rd_cmp16 = 16'h0000;
    case (io_a)
      4'd0:    io_dout = {3'b000, ctrl_q};
      4'd1:    io_dout = 8'(imsk_q);
      4'd2:    io_dout = 8'(iflg_q);
      4'd3:    io_dout = cnt16[7:0];
      4'd4:    io_dout = (WIDTH == 16) ? temp_q : 8'h00;
      default: ;
    endcase
    for (int k = 0; k < NCMP; k++) begin
      rd_cmp16 = 16'(cmp_sh_q[k]);
      if (io_a == 4'(5 + 2 * k)) io_dout = rd_cmp16[7:0];
      if ((io_a == 4'(6 + 2 * k)) && (WIDTH == 16)) io_dout = rd_cmp16[15:8];
    end
  end

  assign oc      = oc_q;
  assign irq_ovf = irq_ovf_q;
  assign irq_cmp = irq_cmp_q;
endmodule

// File: tb/tb_avr_timer_n.sv
// tb/tb_avr_timer_n.sv - directed self-checking bench for avr_timer_n (8- and 16-bit instances)
`timescale 1ns/1ps
module tb_avr_timer_n;
  logic       clock = 1'b0;
  logic       reset, locked;
  logic [3:0] io_a;
  logic [7:0] io_din;
  logic       io_w, io_r;
  logic       ack_ovf;
  logic [1:0] ack_cmp;
  logic [7:0] dout8, dout16;
  logic [1:0] oc8, oc16, irq_cmp8, irq_cmp16;
  logic       irq_ovf8, irq_ovf16;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  avr_timer_n #(.WIDTH(8), .NCMP(2)) dut8 (
    .clock(clock), .reset(reset), .locked(locked), .io_a(io_a), .io_din(io_din),
    .io_w(io_w), .io_r(io_r), .io_dout(dout8), .oc(oc8), .irq_ovf(irq_ovf8),
    .irq_cmp(irq_cmp8), .ack_ovf(ack_ovf), .ack_cmp(ack_cmp)
  );

  avr_timer_n #(.WIDTH(16), .NCMP(2)) dut16 (
    .clock(clock), .reset(reset), .locked(locked), .io_a(io_a), .io_din(io_din),
    .io_w(io_w), .io_r(io_r), .io_dout(dout16), .oc(oc16), .irq_ovf(irq_ovf16),
    .irq_cmp(irq_cmp16), .ack_ovf(ack_ovf), .ack_cmp(ack_cmp)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    io_a = a; io_din = d; io_w = 1'b1;
    step(1);
    io_w = 1'b0;
  endtask

  task automatic rd8(input logic [3:0] a, output logic [7:0] v);
    io_a = a;
    #1;
    v = dout8;
  endtask

  task automatic rd16(input logic [3:0] a, output logic [7:0] v);
    io_a = a;
    #1;
    v = dout16;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    do_reset();
    for (int a = 0; a < 16; a++) begin
      rd8(4'(a), v);
      n_cmp++;
      if (v !== 8'h00) begin n_bad++; $display("FAIL reset_reg%0d: got %02h want 00", a, v); end
      rd16(4'(a), v);
      n_cmp++;
      if (v !== 8'h00) begin n_bad++; $display("FAIL reset16_reg%0d: got %02h want 00", a, v); end
    end
    n_cmp++;
    if ({oc8, irq_cmp8, irq_ovf8} !== 5'b0) begin
      n_bad++; $display("FAIL reset_outputs: got %05b want 00000", {oc8, irq_cmp8, irq_ovf8});
    end
  endtask

  task automatic test_normal_ovf();
    logic [7:0] v;
    do_reset();
    wr(4'd1, 8'h01);
    wr(4'd3, 8'hFA);
    wr(4'd0, 8'h01);
    step(5);
    rd8(4'd3, v);
    n_cmp++;
    if (v !== 8'hFF) begin n_bad++; $display("FAIL ovf_cnt_top: got %02h want ff", v); end
    step(1);
    rd8(4'd3, v);
    n_cmp++;
    if (v !== 8'h00) begin n_bad++; $display("FAIL ovf_cnt_wrap: got %02h want 00", v); end
    rd8(4'd2, v);
    n_cmp++;
    if (v !== 8'h01) begin n_bad++; $display("FAIL ovf_flag: got %02h want 01", v); end
    n_cmp++;
    if (irq_ovf8 !== 1'b0) begin n_bad++; $display("FAIL ovf_irq_early: got %b want 0", irq_ovf8); end
    step(1);
    n_cmp++;
    if (irq_ovf8 !== 1'b1) begin n_bad++; $display("FAIL ovf_irq: got %b want 1", irq_ovf8); end
    wr(4'd2, 8'h01);
    step(1);
    n_cmp++;
    if (irq_ovf8 !== 1'b0) begin n_bad++; $display("FAIL ovf_irq_clear: got %b want 0", irq_ovf8); end
    rd8(4'd2, v);
    n_cmp++;
    if (v[0] !== 1'b0) begin n_bad++; $display("FAIL ovf_w1c: got %b want 0", v[0]); end
  endtask

  task automatic test_prescaler();
    logic [7:0] a0, a1, d;
    do_reset();
    wr(4'd0, 8'h02);
    rd8(4'd3, a0); step(8); rd8(4'd3, a1); d = a1 - a0;
    n_cmp++;
    if (d !== 8'd1) begin n_bad++; $display("FAIL presc8_8clk: got %0d want 1", d); end
    rd8(4'd3, a0); step(64); rd8(4'd3, a1); d = a1 - a0;
    n_cmp++;
    if (d !== 8'd8) begin n_bad++; $display("FAIL presc8_64clk: got %0d want 8", d); end
    wr(4'd0, 8'h05);
    for (int i = 0; i < 2; i++) begin
      rd8(4'd3, a0); step(1024); rd8(4'd3, a1); d = a1 - a0;
      n_cmp++;
      if (d !== 8'd1) begin n_bad++; $display("FAIL presc1024_%0d: got %0d want 1", i, d); end
    end
    wr(4'd0, 8'h00);
    rd8(4'd3, a0); step(2000); rd8(4'd3, a1); d = a1 - a0;
    n_cmp++;
    if (d !== 8'd0) begin n_bad++; $display("FAIL presc_stopped: got %0d want 0", d); end
  endtask

  task automatic test_ctc();
    logic [7:0] v;
    do_reset();
    wr(4'd5, 8'd9);
    wr(4'd0, 8'h09);
    for (int j = 1; j <= 20; j++) begin
      step(1);
      rd8(4'd3, v);
      n_cmp++;
      if (v !== 8'(j % 10)) begin n_bad++; $display("FAIL ctc_cnt_%0d: got %0d want %0d", j, v, j % 10); end
      n_cmp++;
      if (oc8[0] !== ((j >= 10) && (j < 20))) begin
        n_bad++; $display("FAIL ctc_oc0_%0d: got %b want %b", j, oc8[0], (j >= 10) && (j < 20));
      end
      if (j == 9 || j == 10) begin
        rd8(4'd2, v);
        n_cmp++;
        if ((v & 8'h03) !== ((j == 10) ? 8'h02 : 8'h00)) begin
          n_bad++; $display("FAIL ctc_flag_%0d: got %02h want %02h", j, v & 8'h03, (j == 10) ? 2 : 0);
        end
      end
    end
    step(300);
    rd8(4'd2, v);
    n_cmp++;
    if (v[0] !== 1'b0) begin n_bad++; $display("FAIL ctc_no_ovf: got %b want 0", v[0]); end
  endtask

  task automatic test_pwm();
    logic [7:0] v;
    int hi, oc0_hi;
    do_reset();
    wr(4'd7, 8'd64);
    wr(4'd0, 8'h11);
    hi = 0; oc0_hi = 0;
    for (int j = 1; j <= 256; j++) begin
      step(1);
      hi += int'(oc8[1]); oc0_hi += int'(oc8[0]);
      if (j == 1 || j == 64 || j == 65) begin
        n_cmp++;
        if (oc8[1] !== (j != 65)) begin n_bad++; $display("FAIL pwm_edge_%0d: got %b want %b", j, oc8[1], j != 65); end
      end
    end
    n_cmp++;
    if (hi != 64) begin n_bad++; $display("FAIL pwm_duty64: got %0d want 64", hi); end
    step(100);
    wr(4'd7, 8'd192);
    rd8(4'd7, v);
    n_cmp++;
    if (v !== 8'd192) begin n_bad++; $display("FAIL pwm_shadow_rd: got %0d want 192", v); end
    hi = 0;
    for (int j = 358; j <= 512; j++) begin step(1); hi += int'(oc8[1]); oc0_hi += int'(oc8[0]); end
    n_cmp++;
    if (hi != 0) begin n_bad++; $display("FAIL pwm_buffered: got %0d want 0", hi); end
    hi = 0;
    for (int j = 513; j <= 768; j++) begin step(1); hi += int'(oc8[1]); oc0_hi += int'(oc8[0]); end
    n_cmp++;
    if (hi != 192) begin n_bad++; $display("FAIL pwm_duty192: got %0d want 192", hi); end
    n_cmp++;
    if (oc0_hi != 0) begin n_bad++; $display("FAIL pwm_cmp0_zero: got %0d want 0", oc0_hi); end
  endtask

  task automatic test_atomic16();
    logic [7:0] v;
    do_reset();
    wr(4'd4, 8'h12);
    wr(4'd3, 8'hFE);
    wr(4'd0, 8'h01);
    step(1);
    io_a = 4'd3; io_r = 1'b1;
    #1;
    v = dout16;
    n_cmp++;
    if (v !== 8'hFF) begin n_bad++; $display("FAIL a16_read_l: got %02h want ff", v); end
    step(1);
    io_r = 1'b0;
    rd16(4'd4, v);
    n_cmp++;
    if (v !== 8'h12) begin n_bad++; $display("FAIL a16_read_h: got %02h want 12", v); end
    rd16(4'd3, v);
    n_cmp++;
    if (v !== 8'h00) begin n_bad++; $display("FAIL a16_carry: got %02h want 00", v); end
    wr(4'd6, 8'hAB);
    wr(4'd5, 8'hCD);
    wr(4'd2, 8'h07);
    wr(4'd4, 8'hAB);
    wr(4'd3, 8'hCD);
    rd16(4'd3, v);
    n_cmp++;
    if (v !== 8'hCD) begin n_bad++; $display("FAIL a16_write_l: got %02h want cd", v); end
    step(1);
    rd16(4'd3, v);
    n_cmp++;
    if (v !== 8'hCE) begin n_bad++; $display("FAIL a16_next: got %02h want ce", v); end
    rd16(4'd2, v);
    n_cmp++;
    if (v !== 8'h00) begin n_bad++; $display("FAIL a16_no_match: got %02h want 00", v); end
    rd8(4'd4, v);
    n_cmp++;
    if (v !== 8'h00) begin n_bad++; $display("FAIL w8_high_zero: got %02h want 00", v); end
  endtask

  task automatic test_locked();
    logic [7:0] a0, a1, d;
    do_reset();
    wr(4'd0, 8'h01);
    rd8(4'd3, a0);
    locked = 1'b0;
    step(20);
    rd8(4'd3, a1);
    locked = 1'b1;
    d = a1 - a0;
    n_cmp++;
    if (d !== 8'd0) begin n_bad++; $display("FAIL locked_hold: got %0d want 0", d); end
    step(3);
    rd8(4'd3, a1);
    d = a1 - a0;
    n_cmp++;
    if (d !== 8'd3) begin n_bad++; $display("FAIL locked_resume: got %0d want 3", d); end
  endtask

  task automatic test_collision();
    logic [7:0] v;
    do_reset();
    wr(4'd5, 8'd5);
    wr(4'd1, 8'h02);
    wr(4'd0, 8'h01);
    step(5);
    ack_cmp = 2'b01;
    step(1);
    ack_cmp = 2'b00;
    rd8(4'd2, v);
    n_cmp++;
    if ((v & 8'h02) !== 8'h02) begin n_bad++; $display("FAIL coll_set_wins: got %02h want 02", v & 8'h02); end
    step(1);
    n_cmp++;
    if (irq_cmp8 !== 2'b01) begin n_bad++; $display("FAIL coll_irq: got %b want 01", irq_cmp8); end
    n_cmp++;
    if (oc8 !== 2'b11) begin n_bad++; $display("FAIL coll_oc_toggle: got %b want 11", oc8); end
    ack_cmp = 2'b01;
    step(1);
    ack_cmp = 2'b00;
    rd8(4'd2, v);
    n_cmp++;
    if ((v & 8'h02) !== 8'h00) begin n_bad++; $display("FAIL ack_clear: got %02h want 00", v & 8'h02); end
    n_cmp++;
    if (irq_cmp8 !== 2'b01) begin n_bad++; $display("FAIL ack_irq_lag: got %b want 01", irq_cmp8); end
    reset = 1'b1;
    step(1);
    n_cmp++;
    if ({oc8, irq_cmp8, irq_ovf8} !== 5'b0) begin
      n_bad++; $display("FAIL midreset_outputs: got %05b want 00000", {oc8, irq_cmp8, irq_ovf8});
    end
    rd8(4'd3, v);
    n_cmp++;
    if (v !== 8'h00) begin n_bad++; $display("FAIL midreset_cnt: got %02h want 00", v); end
    rd8(4'd0, v);
    n_cmp++;
    if (v !== 8'h00) begin n_bad++; $display("FAIL midreset_ctrl: got %02h want 00", v); end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; locked = 1'b1;
    io_a = 4'd0; io_din = 8'h00; io_w = 1'b0; io_r = 1'b0;
    ack_ovf = 1'b0; ack_cmp = 2'b00;
    test_reset();
    test_normal_ovf();
    test_prescaler();
    test_ctc();
    test_pwm();
    test_atomic16();
    test_locked();
    test_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
